// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline registers: default widths,
// control-bundle bit layout and the all-zero bubble control word.
package mips_pipe_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int RA_W_DEF   = 5;
   localparam int CTRL_W_DEF = 9;

   // Control bundle: {immediate, aluop[1:0], regwrite, memtoreg, memwrite, memread, regdst, alusrc}
   localparam int CTRL_ALUSRC   = 0;
   localparam int CTRL_REGDST   = 1;
   localparam int CTRL_MEMREAD  = 2;
   localparam int CTRL_MEMWRITE = 3;
   localparam int CTRL_MEMTOREG = 4;
   localparam int CTRL_REGWRITE = 5;
   localparam int CTRL_ALUOP_LO = 6;
   localparam int CTRL_ALUOP_HI = 7;
   localparam int CTRL_IMM      = 8;

   localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use hazard compare between the load sitting in EX and the
// instruction presented by decode; shared by the ID/EX and IF/ID stages.
module load_use_detect
   import mips_pipe_pkg::*;
#(
   parameter int RA_W = RA_W_DEF
) (
   input  logic            ex_valid,
   input  logic            ex_memread,
   input  logic [RA_W-1:0] ex_rt,
   input  logic            id_valid,
   input  logic [RA_W-1:0] id_rs,
   input  logic [RA_W-1:0] id_rt,
   input  logic            id_uses_rt,
   output logic            hazard_luse
);

   logic rs_match;
   logic rt_match;

   assign rs_match = (ex_rt == id_rs);
   assign rt_match = id_uses_rt & (ex_rt == id_rt);

   // A load into $0 produces nothing to wait for.
   assign hazard_luse = ex_valid & ex_memread & (ex_rt != '0) & id_valid
                      & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with valid/ready handshake, stall, flush and load-use
// bubble insertion. Optional counters enabled by macro ID_EX_PERF_CNT_EN.
module id_ex_stage_reg
   import mips_pipe_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int RA_W   = RA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [XLEN-1:0]   id_rdata1,
   input  logic [XLEN-1:0]   id_rdata2,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [XLEN-1:0]   id_lui,
   input  logic [RA_W-1:0]   id_rs,
   input  logic [RA_W-1:0]   id_rt,
   input  logic [RA_W-1:0]   id_rd,
   input  logic              id_uses_rt,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              stall,
   input  logic              flush,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_rdata1,
   output logic [XLEN-1:0]   ex_rdata2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [XLEN-1:0]   ex_lui,
   output logic [RA_W-1:0]   ex_rs,
   output logic [RA_W-1:0]   ex_rt,
   output logic [RA_W-1:0]   ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              hazard_luse
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [31:0]       perf_bubbles,
   output logic [31:0]       perf_stalls
`endif
);

   logic              vld_p1;
   logic [CTRL_W-1:0] ctrl_p1;
   logic [XLEN-1:0]   rdata1_p1;
   logic [XLEN-1:0]   rdata2_p1;
   logic [XLEN-1:0]   imm_p1;
   logic [XLEN-1:0]   lui_p1;
   logic [RA_W-1:0]   rs_p1;
   logic [RA_W-1:0]   rt_p1;
   logic [RA_W-1:0]   rd_p1;
   logic              advance;
   logic              luse;

   load_use_detect #(
      .RA_W (RA_W)
   ) u_luse (
      .ex_valid    (vld_p1),
      .ex_memread  (ctrl_p1[CTRL_MEMREAD]),
      .ex_rt       (rt_p1),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .hazard_luse (luse)
   );

   assign advance     = (ex_ready | ~vld_p1) & ~stall;
   assign hazard_luse = luse;
   assign id_ready    = advance & ~luse & ~flush;

   // ---- ID -> EX boundary ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1    <= 1'b0;
         ctrl_p1   <= CTRL_BUBBLE[CTRL_W-1:0];
         rdata1_p1 <= '0;
         rdata2_p1 <= '0;
         imm_p1    <= '0;
         lui_p1    <= '0;
         rs_p1     <= '0;
         rt_p1     <= '0;
         rd_p1     <= '0;
      end else if (flush) begin
         // Data fields hold; only valid and control are cleared.
         vld_p1  <= 1'b0;
         ctrl_p1 <= CTRL_BUBBLE[CTRL_W-1:0];
      end else if (advance) begin
         if (luse || !id_valid) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= CTRL_BUBBLE[CTRL_W-1:0];
         end else begin
            vld_p1    <= 1'b1;
            ctrl_p1   <= id_ctrl;
            rdata1_p1 <= id_rdata1;
            rdata2_p1 <= id_rdata2;
            imm_p1    <= id_imm;
            lui_p1    <= id_lui;
            rs_p1     <= id_rs;
            rt_p1     <= id_rt;
            rd_p1     <= id_rd;
         end
      end
   end

   assign ex_valid  = vld_p1;
   assign ex_ctrl   = ctrl_p1;
   assign ex_rdata1 = rdata1_p1;
   assign ex_rdata2 = rdata2_p1;
   assign ex_imm    = imm_p1;
   assign ex_lui    = lui_p1;
   assign ex_rs     = rs_p1;
   assign ex_rt     = rt_p1;
   assign ex_rd     = rd_p1;

`ifdef ID_EX_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   logic [31:0] bubbles_q;
   logic [31:0] stalls_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubbles_q <= '0;
         stalls_q  <= '0;
      end else begin
         if (!flush && advance && luse) bubbles_q <= sat_inc(bubbles_q);
         if (vld_p1 && !advance)        stalls_q  <= sat_inc(stalls_q);
      end
   end

   assign perf_bubbles = bubbles_q;
   assign perf_stalls  = stalls_q;
`endif

endmodule
